// File: rtl/dbus_xbar_decoder_if.sv
// Bundle of every bus signal around the data-bus decoder: the core-facing
// master port (m_*) and the broadcast/per-slave port (s_*).
// The "slave" modport is the decoder's view, because the decoder is the
// target of the core's master port. The "master" modport is the view of
// the environment around it: the core and the slave devices.
interface dbus_xbar_decoder_if #(
  parameter int N_SLAVES = 4
);
  logic                     m_breq;
  logic                     m_bgnt;
  logic                     m_bstart;
  logic [31:0]              m_addr;
  logic [31:0]              m_wdata;
  logic [1:0]               m_tsize;
  logic                     m_ttype;
  logic [31:0]              m_rdata;
  logic                     m_bdone;
  logic                     m_berror;

  logic [N_SLAVES-1:0]      s_ss;
  logic [N_SLAVES-1:0]      s_bstart;
  logic [31:0]              s_addr;
  logic [31:0]              s_wdata;
  logic [1:0]               s_tsize;
  logic                     s_ttype;
  logic [N_SLAVES*32-1:0]   s_rdata;
  logic [N_SLAVES-1:0]      s_bdone;
  logic [N_SLAVES-1:0]      s_berror;

  modport master (
    output m_breq, m_bstart, m_addr, m_wdata, m_tsize, m_ttype,
    input  m_bgnt, m_rdata, m_bdone, m_berror,
    input  s_ss, s_bstart, s_addr, s_wdata, s_tsize, s_ttype,
    output s_rdata, s_bdone, s_berror
  );

  modport slave (
    input  m_breq, m_bstart, m_addr, m_wdata, m_tsize, m_ttype,
    output m_bgnt, m_rdata, m_bdone, m_berror,
    output s_ss, s_bstart, s_addr, s_wdata, s_tsize, s_ttype,
    input  s_rdata, s_bdone, s_berror
  );
endinterface

// File: rtl/dbus_xbar_decoder.sv
// dbus_xbar_decoder: one data-bus master to N_SLAVES address-decoded slaves.
// The slave is chosen from addr[31:28] at the start strobe and latched for
// the whole transaction. Unmapped addresses complete with a bus error.
// Optional feature macro: DBUS_XBAR_TIMEOUT_EN adds a BUSY watchdog that
// ends a transaction with a bus error after TIMEOUT_CYCLES silent cycles.
module dbus_xbar_decoder #(
  parameter int                    N_SLAVES       = 4,
  parameter logic [N_SLAVES*4-1:0] SLAVE_TAGS     = {4'h3, 4'h2, 4'h1, 4'hF},
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  dbus_xbar_decoder_if.slave bus
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [IDX_W-1:0]    sel_idx;
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic                accept;
  logic                tmo_hit;

  logic [31:0]         rdata_slot [N_SLAVES];
  logic [N_SLAVES-1:0] ss_o;
  logic [N_SLAVES-1:0] bstart_o;
  logic [31:0]         rdata_o;
  logic                bdone_o;
  logic                berror_o;

  // Single master: grant simply mirrors the request; request fields are broadcast.
  assign bus.m_bgnt   = bus.m_breq;
  assign bus.s_addr   = bus.m_addr;
  assign bus.s_wdata  = bus.m_wdata;
  assign bus.s_tsize  = bus.m_tsize;
  assign bus.s_ttype  = bus.m_ttype;

  assign bus.s_ss     = ss_o;
  assign bus.s_bstart = bstart_o;
  assign bus.m_rdata  = rdata_o;
  assign bus.m_bdone  = bdone_o;
  assign bus.m_berror = berror_o;

  // Split the packed slave read-data bus into per-slot words.
  always_comb begin
    for (int i = 0; i < N_SLAVES; i++) begin
      rdata_slot[i] = bus.s_rdata[i*32 +: 32];
    end
  end

  // Address decode; scanning downwards lets the lowest matching slot win.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (bus.m_addr[31:28] == SLAVE_TAGS[i*4 +: 4]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

`ifdef DBUS_XBAR_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Watchdog counts BUSY cycles since the accepted start strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if (state == ST_BUSY) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // Next-state and all slave/master response muxing for the current state.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    ss_o      = '0;
    bstart_o  = '0;
    rdata_o   = '0;
    bdone_o   = 1'b0;
    berror_o  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.m_bstart) begin
          if (hit) begin
            accept            = 1'b1;
            ss_o[hit_idx]     = 1'b1;
            bstart_o[hit_idx] = 1'b1;
            if (bus.s_bdone[hit_idx]) begin
              bdone_o  = 1'b1;
              rdata_o  = rdata_slot[hit_idx];
              berror_o = bus.s_berror[hit_idx];
            end else begin
              state_nxt = ST_BUSY;
            end
          end else begin
            state_nxt = ST_ERR;
          end
        end
      end
      ST_BUSY: begin
        ss_o[sel_idx] = 1'b1;
        if (bus.s_bdone[sel_idx]) begin
          bdone_o   = 1'b1;
          rdata_o   = rdata_slot[sel_idx];
          berror_o  = bus.s_berror[sel_idx];
          state_nxt = ST_IDLE;
        end else if (tmo_hit) begin
          state_nxt = ST_ERR;
        end
      end
      ST_ERR: begin
        bdone_o   = 1'b1;
        berror_o  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and the slave index latched for the transaction lifetime.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      sel_idx <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sel_idx <= hit_idx;
      end
    end
  end

endmodule

// File: tb/tb_dbus_xbar_decoder.sv
// Testbench for dbus_xbar_decoder: directed vectors with a completion
// scoreboard. Slot tags are overridden so that tag 3 is slot 0, tag 2 is
// slot 1, tag 1 is slot 2 and tag F is slot 3.
module tb_dbus_xbar_decoder;

  localparam int NS = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        berror;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t exp_q [$];

  dbus_xbar_decoder_if #(.N_SLAVES(NS)) bus_if ();

  dbus_xbar_decoder #(
    .N_SLAVES       (NS),
    .SLAVE_TAGS     (16'hF123),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic bstart, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic ttype,
                               input logic [1:0] tsize,
                               input logic [NS-1:0] bdone, input logic [NS-1:0] berror);
    bus_if.m_bstart  = bstart;
    bus_if.m_addr    = addr;
    bus_if.m_wdata   = wdata;
    bus_if.m_ttype   = ttype;
    bus_if.m_tsize   = tsize;
    bus_if.s_bdone   = bdone;
    bus_if.s_berror  = berror;
  endtask

  task automatic setRdata(input int slot, input logic [31:0] v);
    bus_if.s_rdata[slot*32 +: 32] = v;
  endtask

  task automatic expectDone(input logic [31:0] rdata, input logic berror);
    exp_t e;
    e.rdata  = rdata;
    e.berror = berror;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, "_ss"},     {28'b0, bus_if.s_ss},     32'h0);
    checkOutput({name, "_bstart"}, {28'b0, bus_if.s_bstart}, 32'h0);
    checkOutput({name, "_bdone"},  {31'b0, bus_if.m_bdone},  32'h0);
    checkOutput({name, "_rdata"},  bus_if.m_rdata,           32'h0);
    checkOutput({name, "_berror"}, {31'b0, bus_if.m_berror}, 32'h0);
  endtask

  task automatic checkDrained(input string name);
    checkOutput(name, exp_q.size(), 32'h0);
  endtask

  // Scoreboard monitor: every completion seen on the master port must match
  // the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus_if.m_bdone === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_bdone: got m_bdone=1 rdata=%h berror=%b, expected no completion",
                 bus_if.m_rdata, bus_if.m_berror);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("bdone_rdata", bus_if.m_rdata, e.rdata);
        checkOutput("bdone_berror", {31'b0, bus_if.m_berror}, {31'b0, e.berror});
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus_if.m_breq   = 1'b0;
    bus_if.s_rdata  = '0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b00, 4'b0000, 4'b0000);
    nextCycle();
    nextCycle();

    // Reset state and grant behaviour
    sample();
    checkIdleOutputs("reset");
    checkOutput("grant_low", {31'b0, bus_if.m_bgnt}, 32'h0);
    nextCycle();
    rst = 1'b0;
    bus_if.m_breq = 1'b1;
    applyStimulus(1'b0, 32'hA5A5_0F0F, 32'h1357_9BDF, 1'b1, 2'b01, 4'b0000, 4'b0000);
    sample();
    checkOutput("grant_high", {31'b0, bus_if.m_bgnt}, 32'h1);
    checkOutput("bcast_addr", bus_if.s_addr, 32'hA5A5_0F0F);
    checkOutput("bcast_wdata", bus_if.s_wdata, 32'h1357_9BDF);
    checkOutput("bcast_tsize", {30'b0, bus_if.s_tsize}, 32'h1);
    checkOutput("bcast_ttype", {31'b0, bus_if.s_ttype}, 32'h1);
    checkIdleOutputs("idle_nostart");
    nextCycle();

    // Slot 3 read with two wait cycles
    applyStimulus(1'b1, 32'hF000_0010, 32'h0, 1'b0, 2'b10, 4'b0000, 4'b0000);
    sample();
    checkOutput("t1_ss_start", {28'b0, bus_if.s_ss}, 32'h8);
    checkOutput("t1_bstart", {28'b0, bus_if.s_bstart}, 32'h8);
    nextCycle();
    applyStimulus(1'b0, 32'hF000_0010, 32'h0, 1'b0, 2'b10, 4'b0000, 4'b0000);
    setRdata(3, 32'h1111_1111);
    sample();
    checkOutput("t1_ss_busy1", {28'b0, bus_if.s_ss}, 32'h8);
    checkOutput("t1_bstart_busy", {28'b0, bus_if.s_bstart}, 32'h0);
    checkOutput("t1_rdata_nodone", bus_if.m_rdata, 32'h0);
    nextCycle();
    bus_if.s_bdone = 4'b1000;
    setRdata(3, 32'hDEAD_BEEF);
    expectDone(32'hDEAD_BEEF, 1'b0);
    sample();
    checkOutput("t1_ss_busy2", {28'b0, bus_if.s_ss}, 32'h8);
    nextCycle();
    bus_if.s_bdone = 4'b0000;
    sample();
    checkIdleOutputs("t1_after");
    nextCycle();
    checkDrained("t1_drained");

    // Slot 0 zero-wait write, then back-to-back start
    applyStimulus(1'b1, 32'h3000_0004, 32'h1234_5678, 1'b1, 2'b01, 4'b0001, 4'b0000);
    setRdata(0, 32'hA5A5_A5A5);
    expectDone(32'hA5A5_A5A5, 1'b0);
    sample();
    checkOutput("t2_bstart", {28'b0, bus_if.s_bstart}, 32'h1);
    checkOutput("t2_ss", {28'b0, bus_if.s_ss}, 32'h1);
    checkOutput("t2_wdata", bus_if.s_wdata, 32'h1234_5678);
    nextCycle();
    applyStimulus(1'b1, 32'h3000_0008, 32'h0, 1'b0, 2'b10, 4'b0001, 4'b0000);
    setRdata(0, 32'h1111_2222);
    expectDone(32'h1111_2222, 1'b0);
    sample();
    checkOutput("t2_b2b_bstart", {28'b0, bus_if.s_bstart}, 32'h1);
    nextCycle();
    applyStimulus(1'b0, 32'h3000_0008, 32'h0, 1'b0, 2'b10, 4'b0000, 4'b0000);
    sample();
    checkIdleOutputs("t2_after");
    nextCycle();
    checkDrained("t2_drained");

    // Unmapped address gives a one-cycle error completion
    applyStimulus(1'b1, 32'h5000_0000, 32'h0, 1'b0, 2'b10, 4'b0000, 4'b0000);
    for (int s = 0; s < NS; s++) setRdata(s, 32'hFACE_0000 + s);
    sample();
    checkOutput("t3_ss", {28'b0, bus_if.s_ss}, 32'h0);
    checkOutput("t3_bstart", {28'b0, bus_if.s_bstart}, 32'h0);
    checkOutput("t3_nodone_yet", {31'b0, bus_if.m_bdone}, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'hF000_0000, 32'h0, 1'b0, 2'b10, 4'b0000, 4'b0000);
    expectDone(32'h0, 1'b1);
    sample();
    checkOutput("t3_err_ss", {28'b0, bus_if.s_ss}, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b10, 4'b0000, 4'b0000);
    sample();
    checkIdleOutputs("t3_after");
    nextCycle();
    checkDrained("t3_drained");

    // Slot 1: neighbour noise ignored, then a slave-signalled error
    applyStimulus(1'b1, 32'h2000_0100, 32'h0, 1'b0, 2'b10, 4'b0000, 4'b0000);
    sample();
    checkOutput("t4_ss_start", {28'b0, bus_if.s_ss}, 32'h2);
    nextCycle();
    applyStimulus(1'b1, 32'hF000_0000, 32'h0, 1'b0, 2'b10, 4'b0100, 4'b0100);
    sample();
    checkOutput("t4_busy_bstart", {28'b0, bus_if.s_bstart}, 32'h0);
    checkOutput("t4_busy_ss", {28'b0, bus_if.s_ss}, 32'h2);
    nextCycle();
    applyStimulus(1'b0, 32'h2000_0100, 32'h0, 1'b0, 2'b10, 4'b0110, 4'b0100);
    setRdata(1, 32'hCAFE_0001);
    setRdata(2, 32'hBAD0_0002);
    expectDone(32'hCAFE_0001, 1'b0);
    sample();
    nextCycle();
    applyStimulus(1'b1, 32'h2000_0200, 32'h0, 1'b0, 2'b10, 4'b0000, 4'b0000);
    sample();
    checkOutput("t4b_ss_start", {28'b0, bus_if.s_ss}, 32'h2);
    nextCycle();
    applyStimulus(1'b0, 32'h2000_0200, 32'h0, 1'b0, 2'b10, 4'b0010, 4'b0110);
    setRdata(1, 32'hCAFE_0003);
    expectDone(32'hCAFE_0003, 1'b1);
    sample();
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 2'b10, 4'b0000, 4'b0000);
    sample();
    checkIdleOutputs("t4_after");
    nextCycle();
    checkDrained("t4_drained");

    // Slot 2 never answers
    applyStimulus(1'b1, 32'h1000_0000, 32'h0, 1'b0, 2'b10, 4'b0000, 4'b0000);
    sample();
    checkOutput("t5_ss_start", {28'b0, bus_if.s_ss}, 32'h4);
    nextCycle();
    bus_if.m_bstart = 1'b0;
`ifdef DBUS_XBAR_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      sample();
      checkOutput($sformatf("t5_busy%0d_ss", k), {28'b0, bus_if.s_ss}, 32'h4);
      checkOutput($sformatf("t5_busy%0d_bdone", k), {31'b0, bus_if.m_bdone}, 32'h0);
      nextCycle();
    end
    expectDone(32'h0, 1'b1);
    sample();
    checkOutput("t5_err_ss", {28'b0, bus_if.s_ss}, 32'h0);
    nextCycle();
    bus_if.s_bdone = 4'b0100;
    setRdata(2, 32'h7777_7777);
    sample();
    checkOutput("t5_late_ss", {28'b0, bus_if.s_ss}, 32'h0);
    nextCycle();
    bus_if.s_bdone = 4'b0000;
`else
    for (int k = 1; k <= 20; k++) begin
      sample();
      checkOutput($sformatf("t5_wait%0d_ss", k), {28'b0, bus_if.s_ss}, 32'h4);
      checkOutput($sformatf("t5_wait%0d_bdone", k), {31'b0, bus_if.m_bdone}, 32'h0);
      nextCycle();
    end
    bus_if.s_bdone = 4'b0100;
    setRdata(2, 32'h7777_7777);
    expectDone(32'h7777_7777, 1'b0);
    sample();
    nextCycle();
    bus_if.s_bdone = 4'b0000;
`endif
    sample();
    checkIdleOutputs("t5_after");
    nextCycle();
    checkDrained("t5_drained");

    // Reset on the second BUSY cycle of a slot-3 read
    applyStimulus(1'b1, 32'hF000_0020, 32'h0, 1'b0, 2'b10, 4'b0000, 4'b0000);
    sample();
    nextCycle();
    bus_if.m_bstart = 1'b0;
    sample();
    checkOutput("t6_busy1_ss", {28'b0, bus_if.s_ss}, 32'h8);
    nextCycle();
    rst = 1'b1;
    sample();
    nextCycle();
    rst = 1'b0;
    sample();
    checkIdleOutputs("t6_post_rst");
    nextCycle();
    applyStimulus(1'b1, 32'hF000_0030, 32'h0, 1'b0, 2'b10, 4'b0000, 4'b0000);
    sample();
    checkOutput("t6_new_bstart", {28'b0, bus_if.s_bstart}, 32'h8);
    nextCycle();
    applyStimulus(1'b0, 32'hF000_0030, 32'h0, 1'b0, 2'b10, 4'b1000, 4'b0000);
    setRdata(3, 32'h0BAD_F00D);
    expectDone(32'h0BAD_F00D, 1'b0);
    sample();
    nextCycle();
    bus_if.s_bdone = 4'b0000;
    sample();
    checkIdleOutputs("t6_after");
    nextCycle();
    checkDrained("t6_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
